i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h68, meaning the 7-bit target address the block answers to.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge; clk SHALL be at least 20x the SCL frequency.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port scl_i  input  1  raw I2C SCL from pad, asynchronous.
REQ-005 SHALL have port sda_i  input  1  raw I2C SDA from pad, asynchronous.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 SHALL have port reg_addr  output  8  register pointer into the external register file.
REQ-008 SHALL have port reg_wdata  output  8  write data byte.
REQ-009 SHALL have port reg_we  output  1  one-cycle write strobe.
REQ-010 SHALL have port reg_re  output  1  one-cycle read strobe.
REQ-011 SHALL have port reg_rdata  input  8  read data, valid the clk cycle after reg_re.
REQ-012 SHALL have port busy  output  1  high while addressed, from the address-ACK bit to STOP, repeated START or NACK exit.
REQ-013 SHALL have port txn_done  output  1  one-cycle pulse on STOP ending an addressed transaction.

Function
REQ-014 SHALL pass scl_i and sda_i through 2-flop synchronizers; edge detection SHALL compare the synchronized value with a third flop.
REQ-015 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-016 START/STOP detection SHALL take priority over any bit event in the same cycle.
REQ-017 SHALL sample SDA on SCL rising edges and change sda_oe only on SCL falling edges; all data is MSB first.
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-019 START from any state SHALL go to ADDR and clear the bit counter; reg_addr SHALL be retained.
REQ-020 STOP from any state SHALL go to IDLE with sda_oe=0.
REQ-021 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR go to ADDR_ACK and drive sda_oe=1 from the 8th SCL falling edge to the next SCL falling edge; otherwise go to WAIT_STOP with no ACK.
REQ-022 After the address ACK, R/W=0 SHALL go to RX_BYTE and R/W=1 SHALL go to TX_LOAD.
REQ-023 RX_BYTE: the first byte after the write address SHALL load reg_addr.
REQ-024 RX_BYTE: each later byte SHALL assert reg_we for one cycle, with reg_wdata = the byte and reg_addr = the pointer, on the clk after the 8th SCL rising edge is detected; reg_addr SHALL then increment.
REQ-025 RX_ACK: every received byte SHALL be ACKed for one bit time, then return to RX_BYTE.
REQ-026 TX_LOAD: SHALL pulse reg_re for one cycle, capture reg_rdata the next cycle into the shift register, and drive sda_oe = ~MSB before the next SCL rising edge.
REQ-027 TX_BYTE: SHALL shift out 8 bits; after the 8th SCL falling edge SHALL set sda_oe=0 and enter TX_ACK.
REQ-028 TX_ACK: SHALL sample the controller's bit on SCL rising; ACK(0) increments reg_addr and goes to TX_LOAD on SCL falling; NACK(1) goes to WAIT_STOP.
REQ-029 reg_addr SHALL increment modulo 256 (8'hFF -> 8'h00).
REQ-030 WAIT_STOP SHALL ignore bits and keep sda_oe=0 until START or STOP.
REQ-031 txn_done SHALL pulse only if busy was high when the STOP was detected.

Reset
REQ-032 When rst=1 at a clk edge: state=IDLE, sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, txn_done=0, synchronizers=1.
REQ-033 Reset mid-transaction SHALL release SDA the next cycle, and SHALL not respond until a fresh START.

Verification
REQ-034 Write START, 0xD0, 0x3B, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg_we pulses with (0x3B,0xA5) then (0x3C,0x5A); txn_done pulses once; final reg_addr=0x3D.
REQ-035 Write START 0xD0 0x3B, repeated START, 0xD1, read 2 bytes (ACK, then NACK), STOP, with reg_rdata = 0x11 at 0x3B and 0x22 at 0x3C -> SDA carries 0x11 then 0x22; reg_re pulses exactly twice; WAIT_STOP entered after the NACK.
REQ-036 Send START, 0xA0, 0x00, STOP -> no ACK; sda_oe stays 0; no reg_we/reg_re; busy=0; txn_done=0.
REQ-037 Write pointer 0xFF followed by data 0x01, 0x02 -> writes land at 0xFF then 0x00 (wrap).
REQ-038 Assert rst while the block drives sda_oe=1 during an ACK -> sda_oe=0 next cycle; a following 0xD1 read starts at reg_addr=0x00.
REQ-039 Inject a STOP in the middle of the data byte of a write -> no reg_we; return to IDLE; txn_done pulses.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target that bridges bus byte transfers onto a simple 8-bit register-file port.
// Write: first byte sets the register pointer, later bytes are written. Read: bytes come from the pointer.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h68
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       txn_done
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        ptr_set_q, ptr_set_d;
  logic        ld_ph_q, ld_ph_d;
  logic        sda_oe_d, reg_we_d, reg_re_d, busy_d, txn_done_d;
  logic [7:0]  reg_addr_d, reg_wdata_d;
  logic        scl_rise, scl_fall, start_det, stop_det, addr_match;
  logic [7:0]  rx_byte;

  // p0/p1 synchronize the pads, p2 holds the previous synchronized value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
    end else begin
      {scl_p0, scl_p1, scl_p2} <= {scl_i, scl_p0, scl_p1};
      {sda_p0, sda_p1, sda_p2} <= {sda_i, sda_p0, sda_p1};
    end
  end

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign start_det  = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det   = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign rx_byte    = {shift_q[6:0], sda_p1};
  assign addr_match = (shift_q[7:1] == DEV_ADDR);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:     if (scl_fall && cnt_q == 4'd8) state_d = addr_match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall) state_d = shift_q[0] ? TX_LOAD : RX_BYTE;
        RX_BYTE:  if (scl_fall && cnt_q == 4'd8) state_d = RX_ACK;
        RX_ACK:   if (scl_fall) state_d = RX_BYTE;
        TX_LOAD:  if (ld_ph_q) state_d = TX_BYTE;
        TX_BYTE:  if (scl_fall && cnt_q == 4'd7) state_d = TX_ACK;
        TX_ACK: begin
          if (scl_rise && sda_p1) state_d = WAIT_STOP;
          else if (scl_fall)      state_d = TX_LOAD;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_set_d   = ptr_set_q;
    ld_ph_d     = 1'b0;
    sda_oe_d    = sda_oe;
    // the pointer advances the cycle after a write strobe so the strobe sees the old pointer
    reg_addr_d  = reg_we ? reg_addr + 8'd1 : reg_addr;
    reg_wdata_d = reg_wdata;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy;
    txn_done_d  = 1'b0;
    if (start_det) begin
      cnt_d     = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ptr_set_d = 1'b0;
    end else if (stop_det) begin
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      txn_done_d = busy;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
          end
          if (scl_fall && cnt_q == 4'd8 && addr_match) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            reg_re_d = shift_q[0];
          end
        end
        RX_BYTE: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (ptr_set_q) begin
                reg_we_d    = 1'b1;
                reg_wdata_d = rx_byte;
              end else begin
                reg_addr_d = rx_byte;
                ptr_set_d  = 1'b1;
              end
            end
          end
          if (scl_fall && cnt_q == 4'd8) sda_oe_d = 1'b1;
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
          end
        end
        TX_LOAD: begin
          // reg_re is high in the first cycle here; read data is valid in the second
          if (!ld_ph_q) begin
            ld_ph_d = 1'b1;
          end else begin
            shift_d  = reg_rdata;
            sda_oe_d = ~reg_rdata[7];
            cnt_d    = 4'd0;
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
            end else begin
              cnt_d    = cnt_q + 4'd1;
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise && sda_p1) begin
            busy_d = 1'b0;
          end else if (scl_fall) begin
            reg_addr_d = reg_addr + 8'd1;
            reg_re_d   = 1'b1;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      ptr_set_q <= 1'b0;
      ld_ph_q   <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      txn_done  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ptr_set_q <= ptr_set_d;
      ld_ph_q   <= ld_ph_d;
      sda_oe    <= sda_oe_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_we    <= reg_we_d;
      reg_re    <= reg_re_d;
      busy      <= busy_d;
      txn_done  <= txn_done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level controller model, register-file model and a transaction-level reference.
module tb_i2c_target;

  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_c = 1'b1;
  logic       sda_c = 1'b1;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy, txn_done;
  logic       sda_l;

  assign sda_l = sda_c & ~sda_oe;

  i2c_target #(.DEV_ADDR(7'h68)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_c), .sda_i(sda_l), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .txn_done(txn_done)
  );

  always #5 clk = ~clk;

  // register file model
  logic [7:0] mem [256];
  logic       pre_en = 1'b0;
  logic [7:0] pre_a = 8'd0, pre_d = 8'd0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  // bus monitor
  logic [7:0] mon_wa[$], mon_wd[$], mon_ra[$];
  int txn_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  always @(negedge clk) begin
    if (reg_we) begin
      mon_wa.push_back(reg_addr);
      mon_wd.push_back(reg_wdata);
    end
    if (reg_re) mon_ra.push_back(reg_addr);
    if (txn_done) txn_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  // reference model state
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr = 8'd0;
  logic [7:0] exp_wa[$], exp_wd[$], exp_ra[$];
  logic [7:0] wbuf [4];
  int base_w, base_r, base_txn, base_oe, base_busy;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic bus_start();
    sda_c = 1'b1; #Q; scl_c = 1'b1; #Q; sda_c = 1'b0; #Q; scl_c = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_c = 1'b0; #Q; scl_c = 1'b1; #Q; sda_c = 1'b1; #Q;
  endtask

  task automatic wbit(input logic b);
    sda_c = b; #Q; scl_c = 1'b1; #(2*Q); scl_c = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    sda_c = 1'b1; #Q; scl_c = 1'b1; #Q; b = sda_l; #Q; scl_c = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack_n);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(nack);
  endtask

  task automatic begin_txn();
    base_w = mon_wa.size(); base_r = mon_ra.size(); base_txn = txn_cnt;
    base_oe = oe_cnt; base_busy = busy_cnt;
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
  endtask

  task automatic end_txn(input int exp_txn, input bit quiet);
    repeat (6) @(negedge clk);
    chk("wr_count", 32'(mon_wa.size() - base_w), 32'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size() && base_w + i < mon_wa.size(); i++) begin
      chk("wr_addr", 32'(mon_wa[base_w + i]), 32'(exp_wa[i]));
      chk("wr_data", 32'(mon_wd[base_w + i]), 32'(exp_wd[i]));
    end
    chk("re_count", 32'(mon_ra.size() - base_r), 32'(exp_ra.size()));
    for (int i = 0; i < exp_ra.size() && base_r + i < mon_ra.size(); i++)
      chk("re_addr", 32'(mon_ra[base_r + i]), 32'(exp_ra[i]));
    chk("txn_done", 32'(txn_cnt - base_txn), 32'(exp_txn));
    chk("reg_addr", 32'(reg_addr), 32'(model_ptr));
    chk("busy_end", 32'(busy), 0);
    chk("sda_oe_end", 32'(sda_oe), 0);
    if (quiet) begin
      chk("oe_cycles", 32'(oe_cnt - base_oe), 0);
      chk("busy_cycles", 32'(busy_cnt - base_busy), 0);
    end
  endtask

  task automatic do_write(input logic [7:0] ptr, input int n, input bit stop_after);
    logic a;
    bus_start();
    wbyte(8'hD0, a); chk("w_addr_ack", 32'(a), 0);
    wbyte(ptr, a);   chk("w_ptr_ack", 32'(a), 0);
    model_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      wbyte(wbuf[i], a); chk("w_data_ack", 32'(a), 0);
      exp_wa.push_back(model_ptr);
      exp_wd.push_back(wbuf[i]);
      model_mem[model_ptr] = wbuf[i];
      model_ptr = model_ptr + 8'd1;
    end
    if (stop_after) bus_stop();
  endtask

  task automatic do_read(input int n);
    logic a;
    logic [7:0] d;
    bus_start();
    wbyte(8'hD1, a); chk("r_addr_ack", 32'(a), 0);
    for (int i = 0; i < n; i++) begin
      rbyte(d, (i == n - 1));
      chk("rd_data", 32'(d), 32'(model_mem[model_ptr]));
      exp_ra.push_back(model_ptr);
      if (i < n - 1) model_ptr = model_ptr + 8'd1;
    end
    chk("nack_busy", 32'(busy), 0);
    bus_stop();
  endtask

  task automatic do_bad(input logic [6:0] a7, input logic rw);
    logic a;
    bus_start();
    wbyte({a7, rw}, a); chk("bad_addr_nack", 32'(a), 1);
    if (!rw) begin
      wbyte(8'h00, a); chk("bad_data_nack", 32'(a), 1);
    end
    bus_stop();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       got, a;
    logic [7:0] ab;
    logic [6:0] a7;
    int         kind, n;

    repeat (3) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_reg_addr", 32'(reg_addr), 0);
    chk("rst_reg_wdata", 32'(reg_wdata), 0);
    chk("rst_reg_we", 32'(reg_we), 0);
    chk("rst_reg_re", 32'(reg_re), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txn_done", 32'(txn_done), 0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    poke(8'h3B, 8'h11);
    poke(8'h3C, 8'h22);

    // basic write with auto-increment
    begin_txn();
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    do_write(8'h3B, 2, 1);
    end_txn(1, 0);
    chk("final_ptr_3d", 32'(reg_addr), 32'h3D);

    // pointer write, repeated START, two-byte read; restore read data first
    poke(8'h3B, 8'h11);
    poke(8'h3C, 8'h22);
    begin_txn();
    do_write(8'h3B, 0, 0);
    do_read(2);
    end_txn(0, 0);

    // wrong address: no response at all
    begin_txn();
    do_bad(7'h50, 1'b0);
    end_txn(0, 1);

    // pointer wrap
    begin_txn();
    wbuf[0] = 8'h01; wbuf[1] = 8'h02;
    do_write(8'hFF, 2, 1);
    end_txn(1, 0);

    // STOP in the middle of a data byte
    begin_txn();
    bus_start();
    wbyte(8'hD0, a); chk("mid_addr_ack", 32'(a), 0);
    wbyte(8'h3B, a); chk("mid_ptr_ack", 32'(a), 0);
    model_ptr = 8'h3B;
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    bus_stop();
    end_txn(1, 0);

    // reset while the target drives the address ACK
    bus_start();
    ab = 8'hD0;
    for (int i = 7; i >= 0; i--) wbit(ab[i]);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (sda_oe) got = 1'b1;
    end
    chk("ack_driven", 32'(got), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_release_sda", 32'(sda_oe), 0);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 8'h00;
    chk("rst_ptr_zero", 32'(reg_addr), 0);
    sda_c = 1'b1;
    repeat (4) @(negedge clk);
    begin_txn();
    do_read(2);
    end_txn(0, 0);

    // randomized transactions
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      begin_txn();
      if (kind <= 1) begin
        n = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        ab = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
        do_write(ab, n, 1);
        end_txn(1, 0);
      end else if (kind == 2) begin
        do_read($urandom_range(1, 3));
        end_txn(0, 0);
      end else begin
        a7 = 7'($urandom_range(0, 127));
        if (a7 == 7'h68) a7 = 7'h50;
        do_bad(a7, 1'($urandom_range(0, 1)));
        end_txn(0, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
